// File: rtl/ram_rd_arb_pkg.sv
// Shared types and helpers for the RAM read command arbiter.
package ram_rd_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int unsigned STAT_WIDTH = 32;
   localparam int unsigned MAX_PORTS  = 16;

   // First asserted request at or above 'start', wrapping at 'ports'.
   // Returns 'start' when nothing is requested (caller only uses it when |req).
   function automatic int unsigned rr_search(input logic [MAX_PORTS-1:0] req,
                                             input int unsigned          start,
                                             input int unsigned          ports);
      int unsigned idx;
      logic        found;
      rr_search = start;
      found     = 1'b0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         idx = start + i;
         if (idx >= ports) idx = idx - ports;
         if (!found && (i < ports) && req[idx[3:0]]) begin
            rr_search = idx;
            found     = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/ram_rd_cmd_arb_if.sv
// Bundle of the per-requester read ports (s_*) and the shared RAM read port (m_*).
// 'master' is the arbiter's view; 'slave' is the view of the requesters plus RAM.
interface ram_rd_cmd_arb_if #(
   parameter int unsigned PORTS       = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned ID_WIDTH    = 8,
   parameter int unsigned RUSER_WIDTH = 1
);
   logic [PORTS*ID_WIDTH-1:0]    s_ram_rd_cmd_id;
   logic [PORTS*ADDR_WIDTH-1:0]  s_ram_rd_cmd_addr;
   logic [PORTS-1:0]             s_ram_rd_cmd_last;
   logic [PORTS-1:0]             s_ram_rd_cmd_en;
   logic [PORTS-1:0]             s_ram_rd_cmd_ready;
   logic [PORTS*ID_WIDTH-1:0]    s_ram_rd_resp_id;
   logic [PORTS*DATA_WIDTH-1:0]  s_ram_rd_resp_data;
   logic [PORTS-1:0]             s_ram_rd_resp_last;
   logic [PORTS*RUSER_WIDTH-1:0] s_ram_rd_resp_user;
   logic [PORTS-1:0]             s_ram_rd_resp_valid;
   logic [PORTS-1:0]             s_ram_rd_resp_ready;

   logic [ID_WIDTH-1:0]          m_ram_rd_cmd_id;
   logic [ADDR_WIDTH-1:0]        m_ram_rd_cmd_addr;
   logic                         m_ram_rd_cmd_last;
   logic                         m_ram_rd_cmd_en;
   logic                         m_ram_rd_cmd_ready;
   logic [ID_WIDTH-1:0]          m_ram_rd_resp_id;
   logic [DATA_WIDTH-1:0]        m_ram_rd_resp_data;
   logic                         m_ram_rd_resp_last;
   logic [RUSER_WIDTH-1:0]       m_ram_rd_resp_user;
   logic                         m_ram_rd_resp_valid;
   logic                         m_ram_rd_resp_ready;

   modport master (
      input  s_ram_rd_cmd_id, s_ram_rd_cmd_addr, s_ram_rd_cmd_last, s_ram_rd_cmd_en,
      output s_ram_rd_cmd_ready,
      output s_ram_rd_resp_id, s_ram_rd_resp_data, s_ram_rd_resp_last, s_ram_rd_resp_user,
      output s_ram_rd_resp_valid,
      input  s_ram_rd_resp_ready,
      output m_ram_rd_cmd_id, m_ram_rd_cmd_addr, m_ram_rd_cmd_last, m_ram_rd_cmd_en,
      input  m_ram_rd_cmd_ready,
      input  m_ram_rd_resp_id, m_ram_rd_resp_data, m_ram_rd_resp_last, m_ram_rd_resp_user,
      input  m_ram_rd_resp_valid,
      output m_ram_rd_resp_ready
   );

   modport slave (
      output s_ram_rd_cmd_id, s_ram_rd_cmd_addr, s_ram_rd_cmd_last, s_ram_rd_cmd_en,
      input  s_ram_rd_cmd_ready,
      input  s_ram_rd_resp_id, s_ram_rd_resp_data, s_ram_rd_resp_last, s_ram_rd_resp_user,
      input  s_ram_rd_resp_valid,
      output s_ram_rd_resp_ready,
      input  m_ram_rd_cmd_id, m_ram_rd_cmd_addr, m_ram_rd_cmd_last, m_ram_rd_cmd_en,
      output m_ram_rd_cmd_ready,
      output m_ram_rd_resp_id, m_ram_rd_resp_data, m_ram_rd_resp_last, m_ram_rd_resp_user,
      output m_ram_rd_resp_valid,
      input  m_ram_rd_resp_ready
   );

endinterface

// File: rtl/ram_rd_arb_route_fifo.sv
// In-order route FIFO: holds the owning port index of every command still
// awaiting its response beat. DEPTH must be a power of two (>= 2).
module ram_rd_arb_route_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // status flags and qualified push/pop (push refused when full, even with a pop)
   always_comb begin
      full    = (count == CW'(DEPTH));
      empty   = (count == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      head    = mem[rd_ptr];
   end

   // pointers wrap naturally at DEPTH; count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage array, no reset needed: entries are only read once written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ram_rd_cmd_arb.sv
// Round-robin, burst-granular arbiter sharing one RAM read port among PORTS
// requesters; responses are steered back in command order via a route FIFO.
// Optional statistics counters: define RAM_RD_ARB_STATS_EN.
module ram_rd_cmd_arb
   import ram_rd_arb_pkg::*;
#(
   parameter int unsigned PORTS       = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned ID_WIDTH    = 8,
   parameter int unsigned RUSER_WIDTH = 1,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   ram_rd_cmd_arb_if.master             bus
`ifdef RAM_RD_ARB_STATS_EN
   ,
   output logic [PORTS*STAT_WIDTH-1:0]  stat_cmd_count,
   output logic [STAT_WIDTH-1:0]        stat_stall_count
`endif
);
   localparam int unsigned IDX_W = $clog2(PORTS);

   arb_state_t            state;
   logic [IDX_W-1:0]      grant_reg;
   logic [IDX_W-1:0]      rr_reg;
   logic [IDX_W-1:0]      next_grant;

   logic [ID_WIDTH-1:0]   cmd_id_a   [PORTS];
   logic [ADDR_WIDTH-1:0] cmd_addr_a [PORTS];

   logic                  in_burst;
   logic                  sel_en;
   logic                  sel_last;
   logic                  cmd_en_int;
   logic                  cmd_accept;
   logic                  resp_ok;
   logic                  resp_rdy_int;
   logic                  resp_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [IDX_W-1:0]      head;

   // split the flattened per-port command fields
   always_comb begin
      for (int unsigned p = 0; p < PORTS; p++) begin
         cmd_id_a[p]   = bus.s_ram_rd_cmd_id[p*ID_WIDTH +: ID_WIDTH];
         cmd_addr_a[p] = bus.s_ram_rd_cmd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // next owner: first requester at or after rr_reg, wrapping
   always_comb begin
      next_grant = IDX_W'(rr_search(MAX_PORTS'(bus.s_ram_rd_cmd_en), 32'(rr_reg), PORTS));
   end

   // command path: only the granted port passes, and only while routing has room
   always_comb begin
      in_burst   = (state == BURST);
      sel_en     = in_burst && bus.s_ram_rd_cmd_en[grant_reg];
      sel_last   = in_burst && bus.s_ram_rd_cmd_last[grant_reg];
      cmd_en_int = sel_en && !fifo_full;
      cmd_accept = cmd_en_int && bus.m_ram_rd_cmd_ready;

      bus.m_ram_rd_cmd_en   = cmd_en_int;
      bus.m_ram_rd_cmd_id   = in_burst ? cmd_id_a[grant_reg]   : '0;
      bus.m_ram_rd_cmd_addr = in_burst ? cmd_addr_a[grant_reg] : '0;
      bus.m_ram_rd_cmd_last = sel_last;

      bus.s_ram_rd_cmd_ready = '0;
      if (in_burst && !fifo_full) bus.s_ram_rd_cmd_ready[grant_reg] = bus.m_ram_rd_cmd_ready;
   end

   // response path: steer each beat to the port at the FIFO head; fields are
   // held at zero while nothing is outstanding so idle outputs stay quiet
   always_comb begin
      resp_ok      = !fifo_empty;
      resp_rdy_int = resp_ok && bus.s_ram_rd_resp_ready[head];
      resp_pop     = bus.m_ram_rd_resp_valid && resp_rdy_int;

      bus.m_ram_rd_resp_ready = resp_rdy_int;
      bus.s_ram_rd_resp_valid = '0;
      if (resp_ok) bus.s_ram_rd_resp_valid[head] = bus.m_ram_rd_resp_valid;

      bus.s_ram_rd_resp_id   = resp_ok ? {PORTS{bus.m_ram_rd_resp_id}}   : '0;
      bus.s_ram_rd_resp_data = resp_ok ? {PORTS{bus.m_ram_rd_resp_data}} : '0;
      bus.s_ram_rd_resp_last = resp_ok ? {PORTS{bus.m_ram_rd_resp_last}} : '0;
      bus.s_ram_rd_resp_user = resp_ok ? {PORTS{bus.m_ram_rd_resp_user}} : '0;
   end

   // arbitration FSM: pick in IDLE, hold grant until the last command is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant_reg <= '0;
         rr_reg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.s_ram_rd_cmd_en) begin
                  grant_reg <= next_grant;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (cmd_accept && sel_last) begin
                  rr_reg <= (grant_reg == IDX_W'(PORTS - 1)) ? '0 : grant_reg + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ram_rd_arb_route_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IDX_W)
   ) u_route_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_accept),
      .din   (grant_reg),
      .pop   (resp_pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef RAM_RD_ARB_STATS_EN
   // free-running counters: accepted commands per port, and granted-but-full stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cmd_count   <= '0;
         stat_stall_count <= '0;
      end else begin
         if (cmd_accept)
            stat_cmd_count[32'(grant_reg)*STAT_WIDTH +: STAT_WIDTH] <=
               stat_cmd_count[32'(grant_reg)*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
         if (sel_en && fifo_full)
            stat_stall_count <= stat_stall_count + 1'b1;
      end
   end
`endif

endmodule
